// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if -- key delivery channel between the scanner and its consumer.
//   key_code  : last accepted key, {row[1:0], col[1:0]}   (scanner -> consumer)
//   key_valid : key_code holds an unconsumed key           (scanner -> consumer)
//   overrun   : sticky, a key was overwritten unacked      (scanner -> consumer)
//   key_ack   : consumer takes key_code                    (consumer -> scanner)
interface keypad_scanner_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       overrun;
    logic       key_ack;

    modport master (output key_code, output key_valid, output overrun, input key_ack);
    modport slave  (input key_code, input key_valid, input overrun, output key_ack);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner -- 4x4 matrix keypad scanner with debounce and a key buffer.
//   clk    : single clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   io_row : row drive, active-low, one-cold
//   io_col : column sense, active-low, asynchronous to clk
//   kbd    : key delivery channel (key_code/key_valid/overrun out, key_ack in)
// The FSM and the row pointer only advance on the "sample edge", once every
// SCAN_DIV clocks, so the synchronized columns have settled after a row change.
module keypad_scanner #(
    parameter int SCAN_DIV     = 16384,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] io_row,
    input  logic [3:0] io_col,
    keypad_scanner_if.master kbd
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_e;

    state_e          state_q, state_d;
    logic [3:0]      col_m_q, col_s_q;
    logic [DW-1:0]   div_q, div_d;
    logic [1:0]      row_q, row_d;
    logic [1:0]      cand_row_q, cand_row_d;
    logic [1:0]      cand_col_q, cand_col_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic            ovr_q, ovr_d;

    logic            sample;
    logic            cand_hi;
    logic [1:0]      low_idx;
    logic            low_found;
    logic            new_key;
    logic [3:0]      new_code;

    // Lowest-numbered column currently pulled low.
    always_comb begin
        low_idx   = 2'd0;
        low_found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!col_s_q[i] && !low_found) begin
                low_idx   = 2'(i);
                low_found = 1'b1;
            end
        end
    end

    always_comb begin
        sample  = (div_q == DIV_LAST);
        div_d   = sample ? '0 : div_q + DW'(1);
        cand_hi = col_s_q[cand_col_q];
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        cnt_d      = cnt_q;
        new_key    = 1'b0;
        new_code   = {cand_row_q, cand_col_q};
        if (sample) begin
            unique case (state_q)
                SCAN: begin
                    if (col_s_q == 4'hF) begin
                        row_d = row_q + 2'd1;
                    end else begin
                        cand_row_d = row_q;
                        cand_col_d = low_idx;
                        cnt_d      = CNT_ONE;
                        if (CNT_ONE == CNT_DONE) begin
                            state_d  = HELD;
                            new_key  = 1'b1;
                            new_code = {row_q, low_idx};
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (cand_hi) begin
                        state_d = SCAN;
                        row_d   = row_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q + CNT_ONE == CNT_DONE) begin
                            state_d = HELD;
                            new_key = 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (cand_hi) begin
                        cnt_d = CNT_ONE;
                        if (CNT_ONE == CNT_DONE) begin
                            state_d = SCAN;
                            row_d   = row_q + 2'd1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (cand_hi) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_q + CNT_ONE == CNT_DONE) begin
                            state_d = SCAN;
                            row_d   = row_q + 2'd1;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // A new key always wins over an ack on the same edge; overrun only
    // reflects whether the previous key was still pending and unacked.
    always_comb begin
        code_d  = code_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (new_key) begin
            code_d  = new_code;
            valid_d = 1'b1;
            if (valid_q) begin
                ovr_d = ~kbd.key_ack;
            end
        end else if (valid_q && kbd.key_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_m_q    <= '1;
            col_s_q    <= '1;
            div_q      <= '0;
            state_q    <= SCAN;
            row_q      <= '0;
            cand_row_q <= '0;
            cand_col_q <= '0;
            cnt_q      <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            col_m_q    <= io_col;
            col_s_q    <= col_m_q;
            div_q      <= div_d;
            state_q    <= state_d;
            row_q      <= row_d;
            cand_row_q <= cand_row_d;
            cand_col_q <= cand_col_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb io_row = ~(4'b0001 << row_q);

    assign kbd.key_code  = code_q;
    assign kbd.key_valid = valid_q;
    assign kbd.overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner -- directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=2).
// A behavioural keypad pulls a column low when its key is pressed and its row is driven.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  io_row;
    logic [3:0]  io_col;
    logic [15:0] pressed = '0;
    logic [3:0]  glitch = '0;
    logic [3:0]  col_model;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    keypad_scanner_if kif ();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_row (io_row),
        .io_col (io_col),
        .kbd    (kif)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_model = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !io_row[r]) col_model[c] = 1'b0;
        io_col = col_model & ~glitch;
    end

    typedef struct {
        string       name;
        logic [15:0] mask;
        logic [3:0]  exp_code;
        logic [3:0]  exp_row;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("rst_row",   32'(io_row), 'hE);
        chk("rst_valid", 32'(kif.key_valid), 0);
        chk("rst_code",  32'(kif.key_code), 0);
        chk("rst_ovr",   32'(kif.overrun), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int unsigned n = 0;
        while (!kif.key_valid && n < 200) begin tick(1); n++; end
        chk(name, 32'(kif.key_valid), 1);
    endtask

    task automatic wait_overrun(input string name);
        int unsigned n = 0;
        while (!kif.overrun && n < 200) begin tick(1); n++; end
        chk(name, 32'(kif.overrun), 1);
    endtask

    task automatic wait_row_leave(input logic [3:0] r, input string name);
        int unsigned n = 0;
        while (io_row == r && n < 200) begin tick(1); n++; end
        chk(name, 32'(io_row != r), 1);
    endtask

    // After reset release with key (1,2) held: first low sample at edge 8,
    // key accepted at edge 12.
    task automatic check_fresh_detect(input string tag);
        tick(11);
        chk({tag, "_valid_e11"}, 32'(kif.key_valid), 0);
        tick(1);
        chk({tag, "_valid_e12"}, 32'(kif.key_valid), 1);
        chk({tag, "_code"}, 32'(kif.key_code), 'h6);
        chk({tag, "_row"}, 32'(io_row), 'hD);
    endtask

    initial begin
        vecs[0] = '{"k00",     16'h0001, 4'h0, 4'b1110};
        vecs[1] = '{"k12",     16'h0040, 4'h6, 4'b1101};
        vecs[2] = '{"k21_k23", 16'h0A00, 4'h9, 4'b1011};
        vecs[3] = '{"k33",     16'h8000, 4'hF, 4'b0111};
        vecs[4] = '{"k13_k20", 16'h0180, 4'h7, 4'b1101};
        kif.key_ack = 1'b0;

        // Idle scan: row walks every 4 clocks, no key.
        do_reset();
        chk("idle_row0", 32'(io_row), 'hE);
        tick(4); chk("idle_row1", 32'(io_row), 'hD);
        tick(4); chk("idle_row2", 32'(io_row), 'hB);
        tick(4); chk("idle_row3", 32'(io_row), 'h7);
        tick(4); chk("idle_row0b", 32'(io_row), 'hE);
        chk("idle_valid", 32'(kif.key_valid), 0);

        // Table: press, accept, frozen row, ack, release, no repeat.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            pressed = vecs[i].mask;
            wait_valid({vecs[i].name, "_valid"});
            chk({vecs[i].name, "_code"}, 32'(kif.key_code), 32'(vecs[i].exp_code));
            chk({vecs[i].name, "_row"}, 32'(io_row), 32'(vecs[i].exp_row));
            tick(8);
            chk({vecs[i].name, "_frozen"}, 32'(io_row), 32'(vecs[i].exp_row));
            kif.key_ack = 1'b1; tick(1); kif.key_ack = 1'b0;
            chk({vecs[i].name, "_acked"}, 32'(kif.key_valid), 0);
            pressed = '0;
            wait_row_leave(vecs[i].exp_row, {vecs[i].name, "_release"});
            tick(8);
            chk({vecs[i].name, "_norepeat"}, 32'(kif.key_valid), 0);
        end

        // Exact timeline for key (1,2), other column ignored while held.
        do_reset();
        pressed = 16'h0040;
        check_fresh_detect("t30");
        pressed = 16'h0050;
        tick(4);
        chk("t30_hold_code", 32'(kif.key_code), 'h6);
        chk("t30_hold_row", 32'(io_row), 'hD);
        pressed = '0;
        kif.key_ack = 1'b1;
        tick(1);
        chk("t30_ack", 32'(kif.key_valid), 0);
        tick(1);
        chk("t30_ack_idle_valid", 32'(kif.key_valid), 0);
        chk("t30_ack_idle_ovr", 32'(kif.overrun), 0);
        kif.key_ack = 1'b0;
        tick(5);
        chk("t30_row_e23", 32'(io_row), 'hD);
        tick(1);
        chk("t30_row_e24", 32'(io_row), 'hB);

        // One-sample glitch on col 0 at row 0.
        do_reset();
        glitch = 4'b0001;
        tick(4);
        glitch = '0;
        chk("glitch_frozen", 32'(io_row), 'hE);
        tick(3);
        chk("glitch_e7", 32'(io_row), 'hE);
        tick(1);
        chk("glitch_row1", 32'(io_row), 'hD);
        chk("glitch_valid", 32'(kif.key_valid), 0);
        tick(4);
        chk("glitch_row2", 32'(io_row), 'hB);
        chk("glitch_valid2", 32'(kif.key_valid), 0);

        // Overrun: second key while the first is unacked.
        do_reset();
        pressed = 16'h0002;
        wait_valid("ovr_first");
        chk("ovr_first_code", 32'(kif.key_code), 'h1);
        pressed = '0;
        wait_row_leave(4'b1110, "ovr_release");
        pressed = 16'h0400;
        wait_overrun("ovr_set");
        chk("ovr_code", 32'(kif.key_code), 'hA);
        chk("ovr_valid", 32'(kif.key_valid), 1);
        kif.key_ack = 1'b1; tick(1); kif.key_ack = 1'b0;
        chk("ovr_ack_valid", 32'(kif.key_valid), 0);
        chk("ovr_ack_ovr", 32'(kif.overrun), 0);
        pressed = '0;

        // Ack on the same edge as a new key.
        do_reset();
        pressed = 16'h0002;
        wait_valid("same_first");
        pressed = '0;
        wait_row_leave(4'b1110, "same_release");
        pressed = 16'h4000;
        tick(15);
        chk("same_pre_valid", 32'(kif.key_valid), 1);
        chk("same_pre_code", 32'(kif.key_code), 'h1);
        kif.key_ack = 1'b1;
        tick(1);
        kif.key_ack = 1'b0;
        chk("same_valid", 32'(kif.key_valid), 1);
        chk("same_ovr", 32'(kif.overrun), 0);
        chk("same_code", 32'(kif.key_code), 'hE);
        tick(1);
        chk("same_valid_hold", 32'(kif.key_valid), 1);
        pressed = '0;

        // Reset during HELD; the still-held key goes through full debounce again.
        do_reset();
        pressed = 16'h0040;
        wait_valid("rh_first");
        do_reset();
        check_fresh_detect("rh");
        pressed = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
